// File: rtl/bcd_stopwatch_if.sv
// Control/display bundle between the stopwatch and its host.
// The host side uses the master modport and the stopwatch uses the slave modport.
interface bcd_stopwatch_if #(
  parameter int NUMCELLS = 4
);
  logic                  start;
  logic                  clear;
  logic                  down;
  logic                  preset_load;
  logic [4*NUMCELLS-1:0] preset;
  logic                  lap;
  logic [4*NUMCELLS-1:0] elapsed;
  logic                  running;
  logic                  expired;
  logic                  overflow;

  modport master (
    output start, clear, down, preset_load, preset, lap,
    input  elapsed, running, expired, overflow
  );

  modport slave (
    input  start, clear, down, preset_load, preset, lap,
    output elapsed, running, expired, overflow
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// N-digit BCD stopwatch/countdown driven by a prescaled tick.
// Defining BCD_STOPWATCH_LAP_EN builds the lap-hold display capture.
//
// state  | meaning
// IDLE   | stopped after reset/clear, waiting for start
// RUN    | prescaler active, digits advance on each tick
// PAUSED | value held, resumes in the latched direction
// DONE   | down-count reached zero, digits held at 0
module bcd_stopwatch #(
  parameter int CLOCKSPEED = 12000000,
  parameter int TICKHZ     = 100,
  parameter int NUMCELLS   = 4
) (
  input logic            clock,
  input logic            rst,
  bcd_stopwatch_if.slave bus
);
  localparam int          W    = 4 * NUMCELLS;
  localparam int          DIV  = CLOCKSPEED / TICKHZ;
  localparam logic [31:0] TERM = 32'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t       state;
  logic [31:0]  presc;
  logic [W-1:0] digits;
  logic [W-1:0] stepped;
  logic [W-1:0] clamped;
  logic         dir_down;
  logic         carry;
  logic         tick;
  logic         done_entry;
  logic         running;
  logic         expired;
  logic         overflow;

  assign tick       = (state == RUN) && (presc == TERM);
  assign done_entry = tick && dir_down && (stepped == '0);

  // One ripple step in the latched direction; carry out means every digit wrapped.
  always_comb begin
    stepped = digits;
    carry   = 1'b1;
    for (int i = 0; i < NUMCELLS; i++) begin
      if (carry) begin
        if (dir_down) begin
          if (digits[4*i +: 4] == 4'd0) begin
            stepped[4*i +: 4] = 4'd9;
          end else begin
            stepped[4*i +: 4] = digits[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digits[4*i +: 4] >= 4'd9) begin
            stepped[4*i +: 4] = 4'd0;
          end else begin
            stepped[4*i +: 4] = digits[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    clamped = bus.preset;
    for (int i = 0; i < NUMCELLS; i++) begin
      if (bus.preset[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      state    <= IDLE;
      presc    <= '0;
      digits   <= '0;
      dir_down <= 1'b0;
      running  <= 1'b0;
      expired  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (bus.clear) begin
        state    <= IDLE;
        presc    <= '0;
        digits   <= '0;
        running  <= 1'b0;
        overflow <= 1'b0;
      end else if (bus.preset_load && state != RUN) begin
        digits <= clamped;
        if (state == DONE) state <= PAUSED;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start && (!bus.down || digits != '0)) begin
              state    <= RUN;
              running  <= 1'b1;
              dir_down <= bus.down;
              presc    <= '0;
            end
          end
          RUN: begin
            presc <= tick ? '0 : presc + 32'd1;
            if (tick) begin
              digits <= stepped;
              if (!dir_down && carry) overflow <= 1'b1;
            end
            // Reaching zero outranks a coincident pause request.
            if (done_entry) begin
              state   <= DONE;
              running <= 1'b0;
              expired <= 1'b1;
              presc   <= '0;
            end else if (bus.start) begin
              state   <= PAUSED;
              running <= 1'b0;
              presc   <= '0;
            end
          end
          PAUSED: begin
            if (bus.start) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.running  = running;
  assign bus.expired  = expired;
  assign bus.overflow = overflow;

`ifdef BCD_STOPWATCH_LAP_EN
  logic         hold;
  logic [W-1:0] cap;

  always_ff @(posedge clock) begin
    if (!rst || bus.clear || done_entry) begin
      hold <= 1'b0;
    end else if (bus.lap && (state == RUN || state == PAUSED)) begin
      hold <= !hold;
      if (!hold) cap <= digits;
    end
  end

  assign bus.elapsed = hold ? cap : digits;
`else
  logic unused_lap;
  assign unused_lap  = bus.lap;
  assign bus.elapsed = digits;
`endif
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: integer-valued reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_stopwatch;
  localparam int NC   = 4;
  localparam int W    = 16;
  localparam int DIV  = 10;
  localparam int MAXV = 9999;
  localparam int MS_IDLE = 0, MS_RUN = 1, MS_PAUSED = 2, MS_DONE = 3;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bcd_stopwatch_if #(.NUMCELLS(NC)) bus ();

  bcd_stopwatch #(
    .CLOCKSPEED(100),
    .TICKHZ    (10),
    .NUMCELLS  (NC)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int   m_st  = MS_IDLE;
  int   m_val = 0;
  int   m_cap = 0;
  int   m_cnt = 0;
  logic m_dir = 1'b0;
  logic m_hold = 1'b0;
  logic m_exp = 1'b0;
  logic m_ovf = 1'b0;
  logic m_valid = 1'b0;

  function automatic logic [W-1:0] to_bcd(int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < NC; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int preset_value(logic [W-1:0] p);
    int v;
    int scale;
    int d;
    v = 0;
    scale = 1;
    for (int i = 0; i < NC; i++) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decimal value as a plain integer, cycle counter since run start.
  always @(posedge clock) begin : model_blk
    int   st, val, cap, cnt;
    logic dir, hold, ex, ovf;
    if (!rst) begin
      m_st <= MS_IDLE; m_val <= 0; m_cnt <= 0; m_dir <= 1'b0;
      m_hold <= 1'b0; m_exp <= 1'b0; m_ovf <= 1'b0; m_valid <= 1'b1;
    end else begin
      st = m_st; val = m_val; cap = m_cap; cnt = m_cnt;
      dir = m_dir; hold = m_hold; ovf = m_ovf; ex = 1'b0;
      if (bus.clear) begin
        st = MS_IDLE; val = 0; cnt = 0; ovf = 1'b0; hold = 1'b0;
      end else begin
`ifdef BCD_STOPWATCH_LAP_EN
        if (bus.lap && (st == MS_RUN || st == MS_PAUSED)) begin
          if (!hold) cap = val;
          hold = !hold;
        end
`endif
        if (bus.preset_load && st != MS_RUN) begin
          val = preset_value(bus.preset);
          if (st == MS_DONE) st = MS_PAUSED;
        end else if (st == MS_IDLE) begin
          if (bus.start && (!bus.down || val != 0)) begin
            st = MS_RUN; dir = bus.down; cnt = 0;
          end
        end else if (st == MS_PAUSED) begin
          if (bus.start) st = MS_RUN;
        end else if (st == MS_RUN) begin
          if (cnt == DIV - 1) begin
            cnt = 0;
            if (dir) begin
              val = (val == 0) ? MAXV : val - 1;
              if (val == 0) begin
                st = MS_DONE; ex = 1'b1; hold = 1'b0;
              end
            end else if (val == MAXV) begin
              val = 0; ovf = 1'b1;
            end else begin
              val = val + 1;
            end
          end else begin
            cnt = cnt + 1;
          end
          if (st == MS_RUN && bus.start) begin
            st = MS_PAUSED; cnt = 0;
          end
        end
      end
      m_st <= st; m_val <= val; m_cap <= cap; m_cnt <= cnt;
      m_dir <= dir; m_hold <= hold; m_exp <= ex; m_ovf <= ovf;
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_elapsed",  32'(bus.elapsed),  32'(to_bcd(m_hold ? m_cap : m_val)));
      check("model_running",  32'(bus.running),  32'(m_st == MS_RUN));
      check("model_expired",  32'(bus.expired),  32'(m_exp));
      check("model_overflow", 32'(bus.overflow), 32'(m_ovf));
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc(1); bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1; cyc(1); bus.clear = 1'b0;
  endtask

  task automatic pulse_load(logic [W-1:0] v);
    bus.preset = v; bus.preset_load = 1'b1; cyc(1); bus.preset_load = 1'b0;
  endtask

  task automatic pulse_lap();
    bus.lap = 1'b1; cyc(1); bus.lap = 1'b0;
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    bus.start = 1'b0; bus.clear = 1'b0; bus.down = 1'b0;
    bus.preset_load = 1'b0; bus.preset = '0; bus.lap = 1'b0;
    cyc(3);
    lit("rst_elapsed",  32'(bus.elapsed),  32'h0);
    lit("rst_running",  32'(bus.running),  32'h0);
    lit("rst_expired",  32'(bus.expired),  32'h0);
    lit("rst_overflow", 32'(bus.overflow), 32'h0);
    rst = 1'b1;
    cyc(2);

    // Up count, 25 ticks
    pulse_start();
    lit("running_after_start", 32'(bus.running), 32'h1);
    cyc(9);
    lit("no_change_cycle9", 32'(bus.elapsed), 32'h0000);
    cyc(1);
    lit("first_tick_cycle10", 32'(bus.elapsed), 32'h0001);
    cyc(240);
    lit("up_25", 32'(bus.elapsed), 32'h0025);
    lit("up_25_running", 32'(bus.running), 32'h1);
    pulse_clear();
    lit("clear_zero", 32'(bus.elapsed), 32'h0000);

    // Overflow wrap
    pulse_load(16'h9998);
    lit("load_9998", 32'(bus.elapsed), 32'h9998);
    pulse_start();
    cyc(10);
    lit("ovf_9999", 32'(bus.elapsed), 32'h9999);
    lit("ovf_not_yet", 32'(bus.overflow), 32'h0);
    cyc(10);
    lit("ovf_wrap_0000", 32'(bus.elapsed), 32'h0000);
    lit("ovf_set", 32'(bus.overflow), 32'h1);
    lit("ovf_still_running", 32'(bus.running), 32'h1);
    cyc(10);
    lit("ovf_0001", 32'(bus.elapsed), 32'h0001);
    pulse_clear();
    lit("clear_ovf", 32'(bus.overflow), 32'h0);
    lit("clear_running", 32'(bus.running), 32'h0);

    // Preset clamp and zero-value down start ignored
    pulse_load(16'hA3F5);
    lit("clamp_load", 32'(bus.elapsed), 32'h9395);
    pulse_clear();
    bus.down = 1'b1;
    pulse_start();
    lit("down_zero_ignored", 32'(bus.running), 32'h0);

    // Down count from 102
    pulse_load(16'h0102);
    pulse_start();
    cyc(10);
    lit("down_0101", 32'(bus.elapsed), 32'h0101);
    cyc(20);
    lit("down_0099", 32'(bus.elapsed), 32'h0099);
    pulse_load(16'h5555);
    lit("load_ignored_run", 32'(bus.elapsed), 32'h0099);
    cyc(988);
    lit("down_0001", 32'(bus.elapsed), 32'h0001);
    lit("no_early_expired", 32'(bus.expired), 32'h0);
    cyc(1);
    lit("down_0000", 32'(bus.elapsed), 32'h0000);
    lit("expired_pulse", 32'(bus.expired), 32'h1);
    lit("done_not_running", 32'(bus.running), 32'h0);
    cyc(1);
    lit("expired_single", 32'(bus.expired), 32'h0);
    pulse_start();
    lit("done_ignores_start", 32'(bus.running), 32'h0);
    pulse_load(16'h0003);
    lit("done_load", 32'(bus.elapsed), 32'h0003);
    pulse_start();
    cyc(30);
    lit("reload_expired", 32'(bus.expired), 32'h1);
    pulse_clear();
    bus.down = 1'b0;

    // Pause / resume
    pulse_start();
    cyc(70);
    lit("pause_7", 32'(bus.elapsed), 32'h0007);
    pulse_start();
    cyc(50);
    lit("paused_hold", 32'(bus.elapsed), 32'h0007);
    lit("paused_running", 32'(bus.running), 32'h0);
    pulse_start();
    cyc(9);
    lit("resume_cycle9", 32'(bus.elapsed), 32'h0007);
    cyc(1);
    lit("resume_cycle10", 32'(bus.elapsed), 32'h0008);

    // clear coincident with a tick and a start
    cyc(9);
    bus.clear = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.clear = 1'b0; bus.start = 1'b0;
    lit("clr_tick_elapsed", 32'(bus.elapsed), 32'h0000);
    lit("clr_tick_running", 32'(bus.running), 32'h0);
    lit("clr_tick_overflow", 32'(bus.overflow), 32'h0);

    // Reset mid-run with overflow set
    pulse_load(16'h9999);
    pulse_start();
    cyc(10);
    lit("pre_rst_ovf", 32'(bus.overflow), 32'h1);
    cyc(5);
    rst = 1'b0;
    cyc(1);
    lit("midrst_elapsed",  32'(bus.elapsed),  32'h0);
    lit("midrst_running",  32'(bus.running),  32'h0);
    lit("midrst_expired",  32'(bus.expired),  32'h0);
    lit("midrst_overflow", 32'(bus.overflow), 32'h0);
    rst = 1'b1;
    cyc(1);

    // Lap hold
    pulse_start();
    cyc(120);
    lit("lap_base", 32'(bus.elapsed), 32'h0012);
    pulse_lap();
    cyc(50);
`ifdef BCD_STOPWATCH_LAP_EN
    lit("lap_frozen", 32'(bus.elapsed), 32'h0012);
`else
    lit("lap_ignored", 32'(bus.elapsed), 32'h0017);
`endif
    pulse_lap();
    lit("lap_release", 32'(bus.elapsed), 32'h0017);
    cyc(5);
    pulse_clear();
    cyc(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
